// File: rtl/mac_kbd_host_link_if.sv
// Command/response handshake between a command source (VIA model or bench) and the
// Mac-side keyboard link engine.
interface mac_kbd_host_link_if;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] rsp_data;
    logic       rsp_valid;
    logic       timeout;
    logic       busy;

    modport master (
        output cmd_data, cmd_valid,
        input  cmd_ready, rsp_data, rsp_valid, timeout, busy
    );

    modport slave (
        input  cmd_data, cmd_valid,
        output cmd_ready, rsp_data, rsp_valid, timeout, busy
    );
endinterface

// File: rtl/mac_kbd_host_link.sv
// Host end of the Mac Plus keyboard link: requests a transfer, shifts a command byte out on
// keyboard-generated clocks, turns the data line around and shifts the one-byte reply in.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | data released, cmd_ready high, waiting for a command
// REQ   | data pulled low to request; waiting for the first kbd clock fall
// TX    | command bits driven on falls, keyboard samples on rises
// TURN  | one tick after the 8th TX rise; data released to hand the line over
// RX    | reply bits shifted in on each rise, MSB first
module mac_kbd_host_link #(
    parameter int TIMEOUT = 2400000,
    parameter int TW      = 22
) (
    input  logic                 clk32,
    input  logic                 _reset,
    input  logic                 clk8_en_p,
    mac_kbd_host_link_if.slave   host,
    input  logic                 kbd_clk_i,
    input  logic                 kbd_dat_i,
    output logic                 kbd_dat_o
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        TX   = 3'd2,
        TURN = 3'd3,
        RX   = 3'd4
    } state_t;

    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    state_t        state;
    logic [7:0]    shreg;
    logic [2:0]    bit_cnt;
    logic [TW-1:0] to_cnt;
    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          clk_prev;
    logic          kbd_dat_q;
    logic          cmd_ready_q;
    logic          busy_q;
    logic [7:0]    rsp_data_q;
    logic          rsp_valid_q;
    logic          timeout_q;

    logic fall, rise, clk_edge, expired;

    always_ff @(posedge clk32) begin
        if (!_reset) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= kbd_clk_i;
            clk_s2 <= clk_s1;
            dat_s1 <= kbd_dat_i;
            dat_s2 <= dat_s1;
        end
    end

    // Edges are judged tick-to-tick so a clock level lasting less than a tick is not seen.
    assign fall     = clk8_en_p &&  clk_prev && !clk_s2;
    assign rise     = clk8_en_p && !clk_prev &&  clk_s2;
    assign clk_edge = fall || rise;
    assign expired  = (state != IDLE) && !clk_edge && (to_cnt == TO_LAST);

    always_ff @(posedge clk32) begin
        if (!_reset) begin
            state       <= IDLE;
            shreg       <= 8'h00;
            bit_cnt     <= 3'd0;
            to_cnt      <= '0;
            clk_prev    <= 1'b1;
            kbd_dat_q   <= 1'b1;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            rsp_data_q  <= 8'h00;
            rsp_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            if (state == IDLE)
                cmd_ready_q <= 1'b1;

            if (clk8_en_p) begin
                clk_prev    <= clk_s2;
                rsp_valid_q <= 1'b0;
                timeout_q   <= 1'b0;

                if (state != IDLE)
                    to_cnt <= clk_edge ? '0 : to_cnt + 1'b1;

                if (expired) begin
                    timeout_q   <= 1'b1;
                    kbd_dat_q   <= 1'b1;
                    state       <= IDLE;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    to_cnt      <= '0;
                    bit_cnt     <= 3'd0;
                end else begin
                    case (state)
                        IDLE: begin
                            kbd_dat_q <= 1'b1;
                            if (host.cmd_valid && cmd_ready_q) begin
                                shreg       <= host.cmd_data;
                                kbd_dat_q   <= 1'b0;
                                state       <= REQ;
                                to_cnt      <= '0;
                                bit_cnt     <= 3'd0;
                                cmd_ready_q <= 1'b0;
                                busy_q      <= 1'b1;
                            end
                        end
                        REQ: begin
                            kbd_dat_q <= 1'b0;
                            if (fall) begin
                                kbd_dat_q <= shreg[7];
                                shreg     <= {shreg[6:0], 1'b0};
                                state     <= TX;
                                to_cnt    <= '0;
                            end
                        end
                        TX: begin
                            if (fall) begin
                                kbd_dat_q <= shreg[7];
                                shreg     <= {shreg[6:0], 1'b0};
                            end else if (rise) begin
                                bit_cnt <= bit_cnt + 3'd1;
                                if (bit_cnt == 3'd7) begin
                                    kbd_dat_q <= 1'b0;
                                    state     <= TURN;
                                    to_cnt    <= '0;
                                end
                            end
                        end
                        TURN: begin
                            kbd_dat_q <= 1'b1;
                            state     <= RX;
                            to_cnt    <= '0;
                        end
                        RX: begin
                            if (rise) begin
                                shreg   <= {shreg[6:0], dat_s2};
                                bit_cnt <= bit_cnt + 3'd1;
                                if (bit_cnt == 3'd7) begin
                                    rsp_data_q  <= {shreg[6:0], dat_s2};
                                    rsp_valid_q <= 1'b1;
                                    state       <= IDLE;
                                    cmd_ready_q <= 1'b1;
                                    busy_q      <= 1'b0;
                                    to_cnt      <= '0;
                                end
                            end
                        end
                        default: begin
                            state     <= IDLE;
                            kbd_dat_q <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    assign kbd_dat_o      = kbd_dat_q;
    assign host.cmd_ready = cmd_ready_q;
    assign host.busy      = busy_q;
    assign host.rsp_data  = rsp_data_q;
    assign host.rsp_valid = rsp_valid_q;
    assign host.timeout   = timeout_q;

endmodule

// File: tb/tb_mac_kbd_host_link.sv
// Bench for mac_kbd_host_link: a behavioural keyboard on the open-drain wires plus a
// byte-level model of what each transfer must deliver.
module tb_mac_kbd_host_link;

    localparam int TO = 64;

    logic clk32     = 1'b0;
    logic clk8_en_p = 1'b0;
    logic _reset    = 1'b0;
    logic kbd_clk_r = 1'b1;
    logic kbd_drive = 1'b1;
    wire  kbd_dat_o_w;
    wire  kbd_dat_i_w = kbd_dat_o_w & kbd_drive;

    mac_kbd_host_link_if host ();

    mac_kbd_host_link #(.TIMEOUT(TO), .TW(8)) dut (
        .clk32     (clk32),
        ._reset    (_reset),
        .clk8_en_p (clk8_en_p),
        .host      (host),
        .kbd_clk_i (kbd_clk_r),
        .kbd_dat_i (kbd_dat_i_w),
        .kbd_dat_o (kbd_dat_o_w)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int n_rsp    = 0;
    int n_to     = 0;
    int div      = 0;
    logic [7:0] last_rsp = 8'h00;

    always #15 clk32 = ~clk32;

    always @(negedge clk32) begin
        div       = (div + 1) % 4;
        clk8_en_p = (div == 0);
    end

    always @(posedge host.rsp_valid) n_rsp++;
    always @(posedge host.timeout)   n_to++;

    initial begin
        #2_700_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_tick(input int n);
        repeat (n) begin
            do @(posedge clk32); while (!clk8_en_p);
        end
        #1;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (kbd_dat_i_w == 1'b0) begin
                ok = 1'b1;
                break;
            end
            wait_tick(1);
        end
    endtask

    // Keyboard clocks nbits and samples the wire on each rise.
    task automatic kbd_clock_in(input int half, input int nbits, output logic [7:0] got);
        got = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            kbd_clk_r = 1'b0;
            wait_tick(half);
            kbd_clk_r = 1'b1;
            got = {got[6:0], kbd_dat_i_w};
            wait_tick(half);
        end
    endtask

    // Keyboard drives reply bits MSB first while its clock is low.
    task automatic kbd_reply(input logic [7:0] b, input int half, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            kbd_clk_r = 1'b0;
            kbd_drive = b[7-i];
            wait_tick(half);
            kbd_clk_r = 1'b1;
            wait_tick(half);
        end
        kbd_drive = 1'b1;
    endtask

    task automatic kbd_exchange(input logic [7:0] cmd, input logic [7:0] reply, input int half,
                                input string tag);
        int r0;
        int t0;
        bit ok;
        logic [7:0] got;
        r0 = n_rsp;
        t0 = n_to;
        wait_req(ok);
        check_val({tag, " request"}, ok, 1);
        if (!ok) return;
        kbd_clock_in(half, 8, got);
        check_val({tag, " cmd on wire"}, got, cmd);
        check_val({tag, " released"}, kbd_dat_i_w, 1);
        kbd_reply(reply, half, 8);
        wait_tick(4);
        last_rsp = reply;
        check_val({tag, " rsp pulses"}, n_rsp - r0, 1);
        check_val({tag, " rsp_data"}, host.rsp_data, last_rsp);
        check_val({tag, " no timeout"}, n_to - t0, 0);
    endtask

    task automatic xfer(input logic [7:0] cmd, input logic [7:0] reply, input int half,
                        input string tag);
        host.cmd_data  = cmd;
        host.cmd_valid = 1'b1;
        wait_tick(1);
        host.cmd_valid = 1'b0;
        check_val({tag, " busy"}, host.busy, 1);
        kbd_exchange(cmd, reply, half, tag);
        check_val({tag, " idle after"}, host.busy, 0);
        check_val({tag, " ready after"}, host.cmd_ready, 1);
    endtask

    initial begin
        int k;
        int r0;
        int t0;
        bit ok;
        logic [7:0] got;
        logic [7:0] c;

        host.cmd_data  = 8'h00;
        host.cmd_valid = 1'b0;

        // reset
        _reset = 1'b0;
        wait_tick(4);
        check_val("rst kbd_dat_o", kbd_dat_o_w, 1);
        check_val("rst cmd_ready", host.cmd_ready, 0);
        check_val("rst busy", host.busy, 0);
        check_val("rst rsp_valid", host.rsp_valid, 0);
        check_val("rst timeout", host.timeout, 0);
        check_val("rst rsp_data", host.rsp_data, 8'h00);
        _reset = 1'b1;
        wait_tick(1);
        check_val("post-rst cmd_ready", host.cmd_ready, 1);

        // inquiry
        xfer(8'h10, 8'h7B, 8, "inquiry");

        // no keyboard: exact timeout latency
        r0 = n_rsp;
        t0 = n_to;
        host.cmd_data  = 8'h14;
        host.cmd_valid = 1'b1;
        wait_tick(1);
        host.cmd_valid = 1'b0;
        check_val("nokbd busy", host.busy, 1);
        k = 0;
        while (k < 2 * TO && !host.timeout) begin
            wait_tick(1);
            k++;
        end
        check_val("nokbd latency", k, TO);
        check_val("nokbd dat released", kbd_dat_o_w, 1);
        check_val("nokbd busy low", host.busy, 0);
        check_val("nokbd ready", host.cmd_ready, 1);
        wait_tick(2);
        check_val("nokbd timeout pulses", n_to - t0, 1);
        check_val("nokbd no rsp", n_rsp - r0, 0);

        // random transfers
        for (int i = 0; i < 6; i++)
            xfer(8'($urandom), 8'($urandom), int'($urandom_range(6, 12)), "rand");

        // stall mid-RX
        r0 = n_rsp;
        t0 = n_to;
        c = 8'($urandom);
        host.cmd_data  = c;
        host.cmd_valid = 1'b1;
        wait_tick(1);
        host.cmd_valid = 1'b0;
        wait_req(ok);
        check_val("stall request", ok, 1);
        kbd_clock_in(7, 8, got);
        check_val("stall cmd on wire", got, c);
        kbd_reply(8'($urandom), 7, 4);
        k = 0;
        while (k < TO + 40 && n_to == t0) begin
            wait_tick(1);
            k++;
        end
        wait_tick(2);
        check_val("stall timeout pulses", n_to - t0, 1);
        check_val("stall no rsp", n_rsp - r0, 0);
        check_val("stall rsp_data kept", host.rsp_data, last_rsp);
        check_val("stall dat released", kbd_dat_o_w, 1);
        check_val("stall idle", host.busy, 0);

        // back-to-back with cmd_valid held
        r0 = n_rsp;
        host.cmd_data  = 8'h16;
        host.cmd_valid = 1'b1;
        wait_tick(1);
        host.cmd_data  = 8'h36;
        check_val("b2b ready low while busy", host.cmd_ready, 0);
        kbd_exchange(8'h16, 8'hA5, 9, "b2b first");
        host.cmd_valid = 1'b0;
        check_val("b2b second accepted", host.busy, 1);
        kbd_exchange(8'h36, 8'h3C, 9, "b2b second");
        check_val("b2b idle after", host.busy, 0);
        check_val("b2b rsp total", n_rsp - r0, 2);

        // reset in the middle of TX
        r0 = n_rsp;
        t0 = n_to;
        host.cmd_data  = 8'h10;
        host.cmd_valid = 1'b1;
        wait_tick(1);
        host.cmd_valid = 1'b0;
        wait_req(ok);
        check_val("midrst request", ok, 1);
        kbd_clock_in(8, 3, got);
        _reset = 1'b0;
        @(posedge clk32);
        #1;
        check_val("midrst dat released", kbd_dat_o_w, 1);
        wait_tick(2);
        _reset   = 1'b1;
        last_rsp = 8'h00;
        kbd_clock_in(8, 5, got);
        wait_tick(TO + 10);
        check_val("midrst no rsp", n_rsp - r0, 0);
        check_val("midrst no timeout", n_to - t0, 0);
        check_val("midrst idle", host.busy, 0);
        check_val("midrst rsp_data cleared", host.rsp_data, last_rsp);
        xfer(8'h10, 8'($urandom), 8, "after midrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
